// File: rtl/add_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial adder: controller states, slice width
// and the carry-combine helper used by carry-lookahead slices and their controllers.
package add_nibble_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int NIBBLE_W = 4;

    function automatic logic carry_combine(input logic g, input logic p, input logic c);
        return g | (p & c);
    endfunction

endpackage

// File: rtl/add_nibble_seq_add4pg.sv
// 4-bit carry-lookahead slice with group propagate/generate outputs so a
// controller can rebuild the carry out of the slice without a ripple.
module add4pg
    import add_nibble_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                pg,
    output logic                gg
);

    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Lookahead carries into each bit, all derived directly from cin.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign s  = p ^ c;
    assign pg = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/add_nibble_seq.sv
// Multi-cycle WIDTH-bit adder: one add4pg slice is time-shared over the operand
// nibbles, LSB first, with the inter-nibble carry held in a register.
module add_nibble_seq
    import add_nibble_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_pg;
    logic                slice_gg;
    logic                carry_next;

    assign slice_a = op_a_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign slice_b = op_b_q[NIBBLE_W*idx_q +: NIBBLE_W];

    add4pg u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_q),
        .s   (slice_s),
        .pg  (slice_pg),
        .gg  (slice_gg)
    );

    assign carry_next = carry_combine(slice_gg, slice_pg, carry_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        s_d     = s_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    carry_d = cin;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[NIBBLE_W*idx_q +: NIBBLE_W] = slice_s;
                carry_d = carry_next;
                idx_d   = idx_q + 1'b1;
                // Final pass: the slice sum bit 3 is the result MSB.
                if (idx_q == LAST_IDX) begin
                    cout_d  = carry_next;
                    ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                              (slice_s[NIBBLE_W-1] != op_a_q[WIDTH-1]);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_add_nibble_seq.sv
// Scoreboard bench for add_nibble_seq: 32-bit directed cases plus an 8-bit instance
// swept over every a with a set of b patterns and both carry-ins.
module tb_add_nibble_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        start32, cin32, busy32, done32, cout32, ovf32;
    logic [31:0] a32, b32, s32;
    logic        start8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, s8;

    add_nibble_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .cin(cin32),
        .busy(busy32), .done(done32), .s(s32), .cout(cout32), .ovf(ovf32)
    );

    add_nibble_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
    );

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        int          edge_n;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (rst_n && done32) begin
            chk("pending32", 32'(q32.size() != 0), 32'd1);
            if (q32.size() != 0) begin
                e32 = q32.pop_front();
                chk("s32", s32, e32.s);
                chk("cout32", 32'(cout32), 32'(e32.cout));
                chk("ovf32", 32'(ovf32), 32'(e32.ovf));
                chk("latency32", 32'(cyc - e32.edge_n), 32'd8);
                chk("busy32_at_done", 32'(busy32), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done8) begin
            chk("pending8", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                chk("s8", 32'(s8), e8.s);
                chk("cout8", 32'(cout8), 32'(e8.cout));
                chk("ovf8", 32'(ovf8), 32'(e8.ovf));
                chk("latency8", 32'(cyc - e8.edge_n), 32'd2);
            end
        end
    end

    task automatic issue32(input logic [31:0] ai, input logic [31:0] bi, input logic ci,
                           input logic [31:0] es, input logic ec, input logic eo);
        a32 = ai; b32 = bi; cin32 = ci; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        q32.push_back('{s: es, cout: ec, ovf: eo, edge_n: cyc});
        chk("busy32_after_start", 32'(busy32), 32'd1);
    endtask

    task automatic wait_done32();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done32) begin ok = 1'b1; break; end
        end
        chk("done32_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_done8();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) begin ok = 1'b1; break; end
        end
        chk("done8_seen", 32'(ok), 32'd1);
    endtask

    task automatic op32(input logic [31:0] ai, input logic [31:0] bi, input logic ci,
                        input logic [31:0] es, input logic ec, input logic eo);
        issue32(ai, bi, ci, es, ec, eo);
        wait_done32();
        @(posedge clk); #1;
        chk("done32_single_pulse", 32'(done32), 32'd0);
    endtask

    function automatic logic [7:0] b_pattern(input int k, input logic [7:0] av);
        case (k)
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h7F;
            3: return 8'h80;
            4: return 8'hFF;
            default: return av ^ 8'h5A;
        endcase
    endfunction

    initial begin
        logic [7:0] av, bv;
        logic [8:0] sum9;
        logic       ov;

        rst_n = 1'b0;
        start32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
        start8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0;
        #12;
        chk("rst_busy32", 32'(busy32), 32'd0);
        chk("rst_done32", 32'(done32), 32'd0);
        chk("rst_s32", s32, 32'd0);
        chk("rst_cout32", 32'(cout32), 32'd0);
        chk("rst_ovf32", 32'(ovf32), 32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        op32(32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0);
        op32(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
        op32(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);

        // Start while busy is ignored; start in the done cycle is accepted.
        issue32(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);
        @(posedge clk); #1;
        a32 = 32'hFFFFFFFF; b32 = 32'h00000001; cin32 = 1'b0; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        chk("busy32_ignored_start", 32'(busy32), 32'd1);
        wait_done32();
        a32 = 32'hFFFFFFFF; b32 = 32'h00000001; cin32 = 1'b0; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        q32.push_back('{s: 32'h00000000, cout: 1'b1, ovf: 1'b0, edge_n: cyc});
        chk("busy32_back_to_back", 32'(busy32), 32'd1);
        chk("done32_falls_on_accept", 32'(done32), 32'd0);
        wait_done32();
        @(posedge clk); #1;

        op32(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);

        // Abort mid-operation: nibbles 0..3 already hold 0xB, cout/ovf still 1.
        a32 = 32'hAAAAAAAA; b32 = 32'h11111111; cin32 = 1'b0; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy32", 32'(busy32), 32'd0);
        chk("abort_done32", 32'(done32), 32'd0);
        chk("abort_s32", s32, 32'd0);
        chk("abort_cout32", 32'(cout32), 32'd0);
        chk("abort_ovf32", 32'(ovf32), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        op32(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0);

        // 8-bit sweep, issued back to back in each done cycle.
        for (int ai = 0; ai < 256; ai++) begin
            for (int k = 0; k < 6; k++) begin
                for (int c = 0; c < 2; c++) begin
                    av   = 8'(ai);
                    bv   = b_pattern(k, av);
                    sum9 = {1'b0, av} + {1'b0, bv} + 9'(c);
                    ov   = (av[7] == bv[7]) && (sum9[7] != av[7]);
                    a8 = av; b8 = bv; cin8 = c[0]; start8 = 1'b1;
                    @(posedge clk); #1;
                    start8 = 1'b0;
                    q8.push_back('{s: 32'(sum9[7:0]), cout: sum9[8], ovf: ov, edge_n: cyc});
                    wait_done8();
                end
            end
        end
        @(posedge clk); #1;
        chk("done8_single_pulse", 32'(done8), 32'd0);

        repeat (4) @(posedge clk);
        #1;
        chk("q32_drained", 32'(q32.size()), 32'd0);
        chk("q8_drained", 32'(q8.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
